// File: rtl/cp0_intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cp0_intr_ctrl_pkg
//
// Shared definitions for the CP0 Status/Cause/Count/Compare block:
//   - mtc0/mfc0 addresses ({reg[4:0], sel[2:0]}) of the four registers
//   - bit positions of the architectural fields inside Status and Cause
//   - reset values of the four registers
//   - an address decoder that turns a CP0 address into a register select
// -----------------------------------------------------------------------------
package cp0_intr_ctrl_pkg;

    // CP0 addresses, {reg, sel}: Status = 12/0, Cause = 13/0,
    // Count = 9/0, Compare = 11/0.
    localparam logic [7:0] cp0addrStatus  = 8'h60;
    localparam logic [7:0] cp0addrCause   = 8'h68;
    localparam logic [7:0] cp0addrCount   = 8'h48;
    localparam logic [7:0] cp0addrCompare = 8'h58;

    // Single-bit field positions.
    localparam int bitIE  = 0;
    localparam int bitEXL = 1;
    localparam int bitBev = 22;
    localparam int bitTI  = 30;
    localparam int bitBD  = 31;

    // Low bit of the multi-bit fields. IM and IP are both 8 bits wide and
    // line up bit for bit, which is what the interrupt mask relies on.
    localparam int imLo      = 8;
    localparam int ipLo      = 8;
    localparam int swIpWidth = 2;
    localparam int excCodeLo = 2;

    // Reset values. Only Bev is set out of reset (boot exception vectors).
    localparam logic [31:0] statusIni  = 32'h0040_0000;
    localparam logic [31:0] causeIni   = 32'h0000_0000;
    localparam logic [31:0] countIni   = 32'h0000_0000;
    localparam logic [31:0] compareIni = 32'h0000_0000;

    // Which register an mtc0 targets. REG_NONE covers unmapped addresses,
    // which must leave every register untouched.
    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_CAUSE,
        REG_COUNT,
        REG_COMPARE
    } cp0Reg_e;

    function automatic cp0Reg_e cp0Decode(input logic [7:0] addr);
        cp0Reg_e sel;
        case (addr)
            cp0addrStatus:  sel = REG_STATUS;
            cp0addrCause:   sel = REG_CAUSE;
            cp0addrCount:   sel = REG_COUNT;
            cp0addrCompare: sel = REG_COMPARE;
            default:        sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cp0_intr_ctrl_sync.sv
// -----------------------------------------------------------------------------
// cp0_int_sync
//
// Multi-stage synchroniser for asynchronous level interrupt lines. Each line
// gets its own chain of STAGES flops; everything is cleared by the async reset
// so no stale interrupt survives a reset.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   async_i  in   WIDTH raw asynchronous lines
//   sync_o   out  WIDTH synchronised lines (output of the last stage)
// -----------------------------------------------------------------------------
module cp0_int_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    // Stage 0 samples the raw lines; each later stage copies the one before
    // it, so a level change reaches sync_o after STAGES clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/cp0_intr_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_intr_ctrl
//
// CP0 Status, Cause, Count and Compare in one block, plus interrupt request
// generation for the exception stage.
//
// Parameters:
//   HW_INT_NUM   number of external interrupt lines (1..6), line i -> IP[2+i]
//   COUNT_DIV    Count increments once every COUNT_DIV cycles (1..16)
//   SYNC_STAGES  synchroniser depth on each ext_int line (1..3)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mtc0_we           CP0 write strobe
//   cp0_addr          {reg[4:0], sel[2:0]} of the register being written
//   mtc0_data         write data
//   exception         exception commit (one cycle), qualifies exc_code/exc_bd
//   exc_code          ExcCode of the committing exception
//   exc_bd            faulting instruction sits in a branch delay slot
//   eret_op           ERET commit (one cycle)
//   ext_int           asynchronous level interrupt lines
//   cp0_*_data        read values of Status, Cause, Count, Compare
//   int_req           registered interrupt request
//
// Every output comes straight from flops (or ORs of flops), so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module cp0_intr_ctrl
    import cp0_intr_ctrl_pkg::*;
#(
    parameter int HW_INT_NUM  = 6,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mtc0_we,
    input  logic [7:0]            cp0_addr,
    input  logic [31:0]           mtc0_data,
    input  logic                  exception,
    input  logic [4:0]            exc_code,
    input  logic                  exc_bd,
    input  logic                  eret_op,
    input  logic [HW_INT_NUM-1:0] ext_int,
    output logic [31:0]           cp0_Status_data,
    output logic [31:0]           cp0_Cause_data,
    output logic [31:0]           cp0_Count_data,
    output logic [31:0]           cp0_Compare_data,
    output logic                  int_req
);

    localparam int PRESC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(COUNT_DIV - 1);

    // Architectural state. Bev is a constant and the hardware IP bits are
    // rebuilt from the synchronisers and TI, so neither needs its own flop.
    logic [7:0]           im_q,      im_d;
    logic                 exl_q,     exl_d;
    logic                 ie_q,      ie_d;
    logic                 bd_q,      bd_d;
    logic                 ti_q,      ti_d;
    logic [swIpWidth-1:0] swIp_q,    swIp_d;
    logic [4:0]           excCode_q, excCode_d;
    logic [31:0]          count_q,   count_d;
    logic [31:0]          compare_q, compare_d;
    logic [PRESC_W-1:0]   presc_q,   presc_d;
    logic                 intReq_q,  intReq_d;

    logic [HW_INT_NUM-1:0] extSync;
    logic [7:0]            ip;
    cp0Reg_e               wrSel;
    logic                  tick;
    logic [31:0]           countInc;

    cp0_int_sync #(
        .WIDTH  (HW_INT_NUM),
        .STAGES (SYNC_STAGES)
    ) u_extSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ext_int),
        .sync_o  (extSync)
    );

    assign wrSel    = mtc0_we ? cp0Decode(cp0_addr) : REG_NONE;
    assign tick     = (presc_q == PRESC_MAX);
    assign countInc = count_q + 32'd1;

    // Assemble Cause.IP: software bits from their flops, one hardware bit per
    // synchronised line starting at IP[2], and the timer interrupt folded
    // into IP[7] alongside the sixth external line when there is one.
    always_comb begin
        ip = '0;
        ip[swIpWidth-1:0] = swIp_q;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            ip[2+i] = extSync[i];
        end
        ip[7] = ip[7] | ti_q;
    end

    // Next-state logic for all registers.
    // EXL ordering: an exception commit beats ERET, which beats an mtc0.
    // BD only latches on an exception taken with EXL clear, so a nested
    // exception keeps the delay-slot flag of the original one.
    // Timer: an mtc0 to Count reloads it and restarts the prescaler, which
    // suppresses that cycle's increment and therefore any match. An mtc0 to
    // Compare clears TI and beats a match on the same tick.
    // The interrupt request is sampled from the present register values so
    // that it lags any state change by exactly one cycle.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ti_d      = ti_q;
        swIp_d    = swIp_q;
        excCode_d = excCode_q;
        count_d   = count_q;
        compare_d = compare_q;
        presc_d   = presc_q;

        if (wrSel == REG_STATUS) begin
            im_d = mtc0_data[imLo +: 8];
            ie_d = mtc0_data[bitIE];
        end

        if (exception) begin
            exl_d = 1'b1;
        end else if (eret_op) begin
            exl_d = 1'b0;
        end else if (wrSel == REG_STATUS) begin
            exl_d = mtc0_data[bitEXL];
        end

        if (exception) begin
            excCode_d = exc_code;
            if (!exl_q) begin
                bd_d = exc_bd;
            end
        end

        if (wrSel == REG_CAUSE) begin
            swIp_d = mtc0_data[ipLo +: swIpWidth];
        end

        if (wrSel == REG_COUNT) begin
            count_d = mtc0_data;
            presc_d = '0;
        end else if (tick) begin
            count_d = countInc;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (wrSel == REG_COMPARE) begin
            compare_d = mtc0_data;
            ti_d      = 1'b0;
        end else if ((wrSel != REG_COUNT) && tick && (countInc == compare_q)) begin
            ti_d = 1'b1;
        end

        intReq_d = ie_q & ~exl_q & (|(ip & im_q));
    end

    // State registers. Reset clears everything asynchronously, including
    // a pending interrupt request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_q      <= statusIni[imLo +: 8];
            exl_q     <= statusIni[bitEXL];
            ie_q      <= statusIni[bitIE];
            bd_q      <= causeIni[bitBD];
            ti_q      <= causeIni[bitTI];
            swIp_q    <= causeIni[ipLo +: swIpWidth];
            excCode_q <= causeIni[excCodeLo +: 5];
            count_q   <= countIni;
            compare_q <= compareIni;
            presc_q   <= '0;
            intReq_q  <= 1'b0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            swIp_q    <= swIp_d;
            excCode_q <= excCode_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
            intReq_q  <= intReq_d;
        end
    end

    // Read values: unimplemented bits read as zero, Bev reads as one.
    always_comb begin
        cp0_Status_data                 = '0;
        cp0_Status_data[bitBev]         = 1'b1;
        cp0_Status_data[imLo +: 8]      = im_q;
        cp0_Status_data[bitEXL]         = exl_q;
        cp0_Status_data[bitIE]          = ie_q;

        cp0_Cause_data                  = '0;
        cp0_Cause_data[bitBD]           = bd_q;
        cp0_Cause_data[bitTI]           = ti_q;
        cp0_Cause_data[ipLo +: 8]       = ip;
        cp0_Cause_data[excCodeLo +: 5]  = excCode_q;
    end

    assign cp0_Count_data   = count_q;
    assign cp0_Compare_data = compare_q;
    assign int_req          = intReq_q;

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_intr_ctrl
//
// Directed self-checking bench for cp0_intr_ctrl with the default parameters
// (6 lines, COUNT_DIV = 2, SYNC_STAGES = 2). Inputs change and outputs are
// sampled on the falling edge; all state changes happen on the rising edge.
// -----------------------------------------------------------------------------
module tb_cp0_intr_ctrl;

    localparam logic [7:0] ADDR_STATUS  = 8'h60;
    localparam logic [7:0] ADDR_CAUSE   = 8'h68;
    localparam logic [7:0] ADDR_COUNT   = 8'h48;
    localparam logic [7:0] ADDR_COMPARE = 8'h58;

    logic        clk;
    logic        rst_n;
    logic        mtc0_we;
    logic [7:0]  cp0_addr;
    logic [31:0] mtc0_data;
    logic        exception;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic        eret_op;
    logic [5:0]  ext_int;
    logic [31:0] cp0_Status_data;
    logic [31:0] cp0_Cause_data;
    logic [31:0] cp0_Count_data;
    logic [31:0] cp0_Compare_data;
    logic        int_req;

    int assertCount = 0;
    int failCount   = 0;

    cp0_intr_ctrl #(
        .HW_INT_NUM  (6),
        .COUNT_DIV   (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mtc0_we          (mtc0_we),
        .cp0_addr         (cp0_addr),
        .mtc0_data        (mtc0_data),
        .exception        (exception),
        .exc_code         (exc_code),
        .exc_bd           (exc_bd),
        .eret_op          (eret_op),
        .ext_int          (ext_int),
        .cp0_Status_data  (cp0_Status_data),
        .cp0_Cause_data   (cp0_Cause_data),
        .cp0_Count_data   (cp0_Count_data),
        .cp0_Compare_data (cp0_Compare_data),
        .int_req          (int_req)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of commit-stage inputs, lets the rising edge take
    // them, then returns the bus to idle on the following falling edge.
    task automatic applyStimulus(input logic we, input logic [7:0] addr,
                                 input logic [31:0] data, input logic exc,
                                 input logic [4:0] code, input logic bd,
                                 input logic eret);
        mtc0_we   = we;
        cp0_addr  = addr;
        mtc0_data = data;
        exception = exc;
        exc_code  = code;
        exc_bd    = bd;
        eret_op   = eret;
        @(negedge clk);
        mtc0_we   = 1'b0;
        cp0_addr  = 8'h00;
        mtc0_data = 32'h0;
        exception = 1'b0;
        exc_code  = 5'h0;
        exc_bd    = 1'b0;
        eret_op   = 1'b0;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 5'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        mtc0_we   = 1'b0;
        cp0_addr  = 8'h00;
        mtc0_data = 32'h0;
        exception = 1'b0;
        exc_code  = 5'h0;
        exc_bd    = 1'b0;
        eret_op   = 1'b0;
        ext_int   = 6'h00;

        // Reset values while held in reset.
        idle(3);
        checkOutput("rst_status",  cp0_Status_data,  32'h0040_0000);
        checkOutput("rst_cause",   cp0_Cause_data,   32'h0);
        checkOutput("rst_count",   cp0_Count_data,   32'h0);
        checkOutput("rst_compare", cp0_Compare_data, 32'h0);
        checkOutput("rst_intreq",  32'(int_req),     32'h0);

        // First Count increment lands on the second edge after release.
        rst_n = 1'b1;
        idle(1);
        checkOutput("count_edge1", cp0_Count_data, 32'd0);
        idle(1);
        checkOutput("count_edge2", cp0_Count_data, 32'd1);

        // Timer: IM[7]=1, IE=1, Compare=3, Count restarted from 0.
        mtc0(ADDR_STATUS, 32'h0000_8001);
        checkOutput("status_wr", cp0_Status_data, 32'h0040_8001);
        mtc0(ADDR_COMPARE, 32'd3);
        checkOutput("compare_wr", cp0_Compare_data, 32'd3);
        mtc0(ADDR_COUNT, 32'd0);
        checkOutput("count_wr", cp0_Count_data, 32'd0);
        idle(5);
        checkOutput("count_pre_match", cp0_Count_data, 32'd2);
        checkOutput("ti_pre_match", 32'(cp0_Cause_data[30]), 32'd0);
        idle(1);
        checkOutput("count_match", cp0_Count_data, 32'd3);
        checkOutput("cause_ti", cp0_Cause_data, 32'h4000_8000);
        checkOutput("intreq_ti_lag", 32'(int_req), 32'd0);
        idle(1);
        checkOutput("intreq_ti", 32'(int_req), 32'd1);
        mtc0(ADDR_COMPARE, 32'd1000);
        checkOutput("ti_cleared", 32'(cp0_Cause_data[30]), 32'd0);
        idle(1);
        checkOutput("intreq_ti_drop", 32'(int_req), 32'd0);

        // External interrupt on line 0 with IM[2]=1.
        mtc0(ADDR_STATUS, 32'h0000_0401);
        ext_int = 6'h01;
        idle(1);
        checkOutput("ip2_edge1", 32'(cp0_Cause_data[10]), 32'd0);
        idle(1);
        checkOutput("ip2_edge2", 32'(cp0_Cause_data[10]), 32'd1);
        checkOutput("intreq_ext_lag", 32'(int_req), 32'd0);
        idle(1);
        checkOutput("intreq_ext", 32'(int_req), 32'd1);

        // Exception fields, then EXL masking the request.
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 5'h04, 1'b1, 1'b0);
        checkOutput("exc_exl", 32'(cp0_Status_data[1]), 32'd1);
        checkOutput("exc_bd", 32'(cp0_Cause_data[31]), 32'd1);
        checkOutput("exc_code", 32'(cp0_Cause_data[6:2]), 32'h04);
        checkOutput("intreq_exl_lag", 32'(int_req), 32'd1);
        idle(1);
        checkOutput("intreq_exl", 32'(int_req), 32'd0);
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 5'h0C, 1'b0, 1'b0);
        checkOutput("exc2_bd_kept", 32'(cp0_Cause_data[31]), 32'd1);
        checkOutput("exc2_code", 32'(cp0_Cause_data[6:2]), 32'h0C);
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 5'h0, 1'b0, 1'b1);
        checkOutput("eret_exl", 32'(cp0_Status_data[1]), 32'd0);
        ext_int = 6'h00;
        idle(4);

        // exception + eret + mtc0 Status(EXL=0) in one cycle: exception wins.
        applyStimulus(1'b1, ADDR_STATUS, 32'h0, 1'b1, 5'h00, 1'b0, 1'b1);
        checkOutput("prio_status", cp0_Status_data, 32'h0040_0002);
        checkOutput("prio_bd", 32'(cp0_Cause_data[31]), 32'd0);
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 5'h0, 1'b0, 1'b1);
        checkOutput("prio_eret", cp0_Status_data, 32'h0040_0000);

        // Compare write on the very tick that would match: TI stays clear.
        mtc0(ADDR_COMPARE, 32'd2);
        mtc0(ADDR_COUNT, 32'd0);
        idle(3);
        checkOutput("cmp_tick_pre", cp0_Count_data, 32'd1);
        mtc0(ADDR_COMPARE, 32'd50);
        checkOutput("cmp_tick_count", cp0_Count_data, 32'd2);
        checkOutput("cmp_tick_ti", 32'(cp0_Cause_data[30]), 32'd0);

        // Count wrap.
        mtc0(ADDR_COUNT, 32'hFFFF_FFFF);
        checkOutput("wrap_load", cp0_Count_data, 32'hFFFF_FFFF);
        idle(1);
        checkOutput("wrap_hold", cp0_Count_data, 32'hFFFF_FFFF);
        idle(1);
        checkOutput("wrap_zero", cp0_Count_data, 32'h0);

        // Software interrupt IP[0] with IM[0]=1, IE=1.
        mtc0(ADDR_STATUS, 32'h0000_0101);
        mtc0(ADDR_CAUSE, 32'h0000_0100);
        checkOutput("swip_cause", 32'(cp0_Cause_data[15:8]), 32'h01);
        checkOutput("swip_intreq_lag", 32'(int_req), 32'd0);
        idle(1);
        checkOutput("swip_intreq", 32'(int_req), 32'd1);
        mtc0(ADDR_CAUSE, 32'h0000_FF00);
        checkOutput("ip_hw_readonly", 32'(cp0_Cause_data[15:8]), 32'h03);

        // Unmapped addresses change nothing.
        mtc0(8'h00, 32'hFFFF_FFFF);
        mtc0(8'h61, 32'hFFFF_FFFF);
        checkOutput("unmapped_status", cp0_Status_data, 32'h0040_0101);
        checkOutput("unmapped_compare", cp0_Compare_data, 32'd50);

        // Asynchronous reset mid-count with Count=5 and TI=1.
        mtc0(ADDR_COMPARE, 32'd5);
        mtc0(ADDR_COUNT, 32'd0);
        idle(10);
        checkOutput("pre_rst_count", cp0_Count_data, 32'd5);
        checkOutput("pre_rst_ti", 32'(cp0_Cause_data[30]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_status",  cp0_Status_data,  32'h0040_0000);
        checkOutput("async_rst_cause",   cp0_Cause_data,   32'h0);
        checkOutput("async_rst_count",   cp0_Count_data,   32'h0);
        checkOutput("async_rst_compare", cp0_Compare_data, 32'h0);
        checkOutput("async_rst_intreq",  32'(int_req),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
